ram_dp_clr: RTL and testbench

- Parametrised successor to the single-port data RAM: one read/write port (A) and one read-only port (B).
- Adds byte-enable writes, selectable read-during-write mode, 1- or 2-cycle read latency with valid strobes, and a sequential clear engine.
- The clear engine zeroes the whole array after reset or on request, instead of clearing every word in one cycle.
- Sits between the core datapath (port A: load/store) and debug/DMA readers (port B).

---
 rtl/ram_dp_clr_if.sv | 30 +++
 rtl/ram_dp_clr.sv | 149 ++++++++++++++
 tb/tb_ram_dp_clr.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_clr_if.sv
// Bus bundle for ram_dp_clr: clear control, read/write port A and read-only port B.
// The master modport drives requests; the slave modport is the RAM side.
interface ram_dp_clr_if #(
  parameter int DW = 32,
  parameter int AW = 12
);
  logic            clr;
  logic            busy;
  logic            a_en;
  logic            a_we;
  logic [DW/8-1:0] a_be;
  logic [AW-1:0]   a_addr;
  logic [DW-1:0]   a_wdata;
  logic [DW-1:0]   a_rdata;
  logic            a_rvalid;
  logic            b_en;
  logic [AW-1:0]   b_addr;
  logic [DW-1:0]   b_rdata;
  logic            b_rvalid;

  modport master (
    output clr, a_en, a_we, a_be, a_addr, a_wdata, b_en, b_addr,
    input  busy, a_rdata, a_rvalid, b_rdata, b_rvalid
  );

  modport slave (
    input  clr, a_en, a_we, a_be, a_addr, a_wdata, b_en, b_addr,
    output busy, a_rdata, a_rvalid, b_rdata, b_rvalid
  );
endinterface

// File: rtl/ram_dp_clr.sv
// Dual-port data RAM: port A read/write with byte enables, port B read-only,
// 1- or 2-cycle read latency and a word-per-cycle clear engine after reset or clr.
module ram_dp_clr #(
  parameter int DW         = 32,
  parameter int AW         = 12,
  parameter int RD_LAT     = 1,
  parameter int WRITE_MODE = 0
) (
  input logic         clk,
  input logic         rst,
  ram_dp_clr_if.slave bus
);
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
    $error("ram_dp_clr: RD_LAT must be 1 or 2");
  end
  if ((DW % 8) != 0) begin : g_bad_dw
    $error("ram_dp_clr: DW must be a multiple of 8");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic          r_busy;
  logic [DW-1:0] r_mem [DEPTH];

  logic          r_a_v1;
  logic [DW-1:0] r_a_d1;
  logic          r_b_v1;
  logic [DW-1:0] r_b_d1;

  logic          w_a_acc;
  logic          w_b_acc;
  logic          w_a_wr;
  logic          w_clr_wr;
  logic [DW-1:0] w_a_old;
  logic [DW-1:0] w_a_merged;
  logic [DW-1:0] w_a_rd;
  logic [DW-1:0] w_b_rd;

  assign w_a_acc  = bus.a_en && !r_busy && !rst;
  assign w_b_acc  = bus.b_en && !r_busy && !rst;
  assign w_a_wr   = w_a_acc && bus.a_we;
  assign w_clr_wr = (r_state == CLEAR) && !rst;
  assign w_a_old  = r_mem[bus.a_addr];

  always_comb begin
    w_a_merged = w_a_old;
    for (int k = 0; k < NB; k++) begin
      if (bus.a_be[k]) w_a_merged[k*8 +: 8] = bus.a_wdata[k*8 +: 8];
    end
  end

  // Write-first forwards the byte-merged word to any same-address read.
  assign w_a_rd = ((WRITE_MODE != 0) && w_a_wr) ? w_a_merged : w_a_old;
  assign w_b_rd = ((WRITE_MODE != 0) && w_a_wr && (bus.b_addr == bus.a_addr)) ?
                  w_a_merged : r_mem[bus.b_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.clr) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == {AW{1'b1}}) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Array has no reset; the clear engine and port A never write in the same cycle.
  always_ff @(posedge clk) begin
    if (w_clr_wr) begin
      r_mem[r_ptr] <= '0;
    end else if (w_a_wr) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.a_be[k]) r_mem[bus.a_addr][k*8 +: 8] <= bus.a_wdata[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_v1 <= 1'b0;
      r_a_d1 <= '0;
      r_b_v1 <= 1'b0;
      r_b_d1 <= '0;
    end else begin
      r_a_v1 <= w_a_acc;
      r_b_v1 <= w_b_acc;
      if (w_a_acc) r_a_d1 <= w_a_rd;
      if (w_b_acc) r_b_d1 <= w_b_rd;
    end
  end

  assign bus.busy = r_busy;

  if (RD_LAT == 2) begin : g_lat2
    logic          r_a_v2;
    logic [DW-1:0] r_a_d2;
    logic          r_b_v2;
    logic [DW-1:0] r_b_d2;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_a_v2 <= 1'b0;
        r_a_d2 <= '0;
        r_b_v2 <= 1'b0;
        r_b_d2 <= '0;
      end else begin
        r_a_v2 <= r_a_v1;
        r_b_v2 <= r_b_v1;
        if (r_a_v1) r_a_d2 <= r_a_d1;
        if (r_b_v1) r_b_d2 <= r_b_d1;
      end
    end

    assign bus.a_rdata  = r_a_d2;
    assign bus.a_rvalid = r_a_v2;
    assign bus.b_rdata  = r_b_d2;
    assign bus.b_rvalid = r_b_v2;
  end else begin : g_lat1
    assign bus.a_rdata  = r_a_d1;
    assign bus.a_rvalid = r_a_v1;
    assign bus.b_rdata  = r_b_d1;
    assign bus.b_rvalid = r_b_v1;
  end
endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: two instances driven identically (RD_LAT=1 read-first,
// RD_LAT=2 write-first) with a per-port scoreboard of expected data and cycle.
module tb_ram_dp_clr;
  localparam int DW = 32;
  localparam int AW = 4;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tClr = 1'b0;
  logic        tAEn = 1'b0;
  logic        tAWe = 1'b0;
  logic [3:0]  tABe = '0;
  logic [3:0]  tAAddr = '0;
  logic [31:0] tAWdata = '0;
  logic        tBEn = 1'b0;
  logic [3:0]  tBAddr = '0;

  int          cyc = 0;
  int          nChecks = 0;
  int          nPass = 0;
  logic        mBusy = 1'b1;
  logic [31:0] model [16];
  exp_t        sb [4][$];
  exp_t        monE;

  logic [3:0]  rvAll;
  logic [31:0] rdAll [4];

  ram_dp_clr_if #(.DW(DW), .AW(AW)) if0 ();
  ram_dp_clr_if #(.DW(DW), .AW(AW)) if1 ();

  assign if0.clr = tClr;     assign if1.clr = tClr;
  assign if0.a_en = tAEn;    assign if1.a_en = tAEn;
  assign if0.a_we = tAWe;    assign if1.a_we = tAWe;
  assign if0.a_be = tABe;    assign if1.a_be = tABe;
  assign if0.a_addr = tAAddr; assign if1.a_addr = tAAddr;
  assign if0.a_wdata = tAWdata; assign if1.a_wdata = tAWdata;
  assign if0.b_en = tBEn;    assign if1.b_en = tBEn;
  assign if0.b_addr = tBAddr; assign if1.b_addr = tBAddr;

  ram_dp_clr #(.DW(DW), .AW(AW), .RD_LAT(1), .WRITE_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  ram_dp_clr #(.DW(DW), .AW(AW), .RD_LAT(2), .WRITE_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  assign rvAll    = {if1.b_rvalid, if1.a_rvalid, if0.b_rvalid, if0.a_rvalid};
  assign rdAll[0] = if0.a_rdata;
  assign rdAll[1] = if0.b_rdata;
  assign rdAll[2] = if1.a_rdata;
  assign rdAll[3] = if1.b_rdata;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: every valid strobe must match the oldest prediction in data and cycle.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (rvAll[p] !== 1'b0) begin
        nChecks++;
        if (sb[p].size() == 0) begin
          $display("[TB] FAIL sb_port%0d unexpected rvalid got data %h at cycle %0d, required no valid", p, rdAll[p], cyc);
        end else begin
          monE = sb[p].pop_front();
          if (rdAll[p] !== monE.data || cyc != monE.cyc)
            $display("[TB] FAIL sb_port%0d got %h at cycle %0d, required %h at cycle %0d", p, rdAll[p], cyc, monE.data, monE.cyc);
          else
            nPass++;
        end
      end
    end
  end

  // One clock of stimulus; predictions are pushed only when the model says ports are live.
  task automatic drive(input logic aEn, input logic aWe, input logic [3:0] aBe,
                       input logic [3:0] aAddr, input logic [31:0] aWd,
                       input logic bEn, input logic [3:0] bAddr, input logic clrIn);
    logic [31:0] aOld, merged, bOld;
    logic        startClear;
    exp_t        e;
    tAEn = aEn; tAWe = aWe; tABe = aBe; tAAddr = aAddr; tAWdata = aWd;
    tBEn = bEn; tBAddr = bAddr; tClr = clrIn;
    startClear = clrIn && !mBusy;
    if (!mBusy) begin
      aOld = model[aAddr];
      bOld = model[bAddr];
      merged = aOld;
      for (int k = 0; k < 4; k++)
        if (aBe[k]) merged[k*8 +: 8] = aWd[k*8 +: 8];
      if (aEn) begin
        e.cyc = cyc + 1; e.data = aOld;                   sb[0].push_back(e);
        e.cyc = cyc + 2; e.data = aWe ? merged : aOld;    sb[2].push_back(e);
      end
      if (bEn) begin
        e.cyc = cyc + 1; e.data = bOld; sb[1].push_back(e);
        e.cyc = cyc + 2;
        e.data = (aEn && aWe && bAddr == aAddr) ? merged : bOld;
        sb[3].push_back(e);
      end
      if (aEn && aWe) model[aAddr] = merged;
    end
    @(negedge clk);
    tAEn = 1'b0; tAWe = 1'b0; tABe = '0; tBEn = 1'b0; tClr = 1'b0;
    if (startClear) begin
      mBusy = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = '0;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 8) begin
      drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0);
      n++;
    end
    drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0);
    nChecks++;
    if ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0)
      $display("[TB] FAIL drain pending %0d/%0d/%0d/%0d, required all 0", sb[0].size(), sb[1].size(), sb[2].size(), sb[3].size());
    else
      nPass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mBusy = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    @(negedge clk);
    @(negedge clk);
    nChecks++;
    if (if0.busy !== 1'b1 || if0.a_rdata !== 32'h0 || if0.b_rdata !== 32'h0 ||
        if1.a_rdata !== 32'h0 || if1.b_rdata !== 32'h0)
      $display("[TB] FAIL reset_state busy=%b rdata=%h/%h/%h/%h, required 1 and zeros",
               if0.busy, if0.a_rdata, if0.b_rdata, if1.a_rdata, if1.b_rdata);
    else
      nPass++;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nChecks++;
      if (if0.busy !== 1'b1 || if1.busy !== 1'b1)
        $display("[TB] FAIL reset_busy_%0d got %b/%b, required 1", i, if0.busy, if1.busy);
      else
        nPass++;
      drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0);
    end
    nChecks++;
    if (if0.busy !== 1'b0 || if1.busy !== 1'b0)
      $display("[TB] FAIL reset_busy_end got %b/%b, required 0", if0.busy, if1.busy);
    else
      nPass++;
    mBusy = 1'b0;
    for (int i = 0; i < 16; i++) drive(1, 0, 4'h0, 4'(i), 32'h0, 1, 4'(15 - i), 0);
    waitDrain();
  endtask

  task automatic test_byte_enable();
    drive(1, 1, 4'hF, 4'd3, 32'hAABBCCDD, 0, 4'h0, 0);
    drive(1, 1, 4'h5, 4'd3, 32'h11223344, 0, 4'h0, 0);
    drive(1, 1, 4'h0, 4'd3, 32'hFFFFFFFF, 0, 4'h0, 0);
    drive(1, 0, 4'h0, 4'd3, 32'h0, 0, 4'h0, 0);
    drive(0, 0, 4'h0, 4'h0, 32'h0, 1, 4'd3, 0);
    waitDrain();
    nChecks++;
    if (if0.a_rdata !== 32'hAA22CC44 || if0.a_rvalid !== 1'b0 || if1.b_rdata !== 32'hAA22CC44)
      $display("[TB] FAIL be_hold got a=%h v=%b b=%h, required AA22CC44 0 AA22CC44",
               if0.a_rdata, if0.a_rvalid, if1.b_rdata);
    else
      nPass++;
  endtask

  task automatic test_collision();
    drive(1, 1, 4'hF, 4'd5, 32'h00000001, 0, 4'h0, 0);
    drive(1, 1, 4'hF, 4'd5, 32'hFFFFFFFF, 1, 4'd5, 0);
    waitDrain();
    nChecks++;
    if (if0.b_rdata !== 32'h00000001 || if1.b_rdata !== 32'hFFFFFFFF ||
        if0.a_rdata !== 32'h00000001 || if1.a_rdata !== 32'hFFFFFFFF)
      $display("[TB] FAIL collision got rf a=%h b=%h wf a=%h b=%h, required 1 1 FFFFFFFF FFFFFFFF",
               if0.a_rdata, if0.b_rdata, if1.a_rdata, if1.b_rdata);
    else
      nPass++;
    drive(1, 1, 4'hF, 4'd6, 32'h12345678, 1, 4'd5, 0);
    waitDrain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) drive(1, 1, 4'hF, 4'(i), 32'h10 + i, 0, 4'h0, 0);
    waitDrain();
    drive(1, 0, 4'h0, 4'd0, 32'h0, 1, 4'd2, 0);
    drive(1, 0, 4'h0, 4'd1, 32'h0, 1, 4'd1, 0);
    drive(1, 0, 4'h0, 4'd2, 32'h0, 1, 4'd0, 0);
    nChecks++;
    if (if1.a_rvalid !== 1'b1 || if1.a_rdata !== 32'h11 || if0.a_rdata !== 32'h12)
      $display("[TB] FAIL b2b_mid got lat2 v=%b d=%h lat1 d=%h, required 1 11 12",
               if1.a_rvalid, if1.a_rdata, if0.a_rdata);
    else
      nPass++;
    waitDrain();
  endtask

  task automatic test_clear_mid();
    drive(1, 1, 4'hF, 4'd7, 32'h0000005A, 0, 4'h0, 0);
    drive(0, 0, 4'h0, 4'h0, 32'h0, 1, 4'd7, 1);
    for (int i = 0; i < 16; i++) begin
      nChecks++;
      if (if0.busy !== 1'b1 || if1.busy !== 1'b1)
        $display("[TB] FAIL clr_busy_%0d got %b/%b, required 1", i, if0.busy, if1.busy);
      else
        nPass++;
      if (i == 2) drive(1, 1, 4'hF, 4'd7, 32'h00000099, 1, 4'd7, 0);
      else        drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0);
    end
    nChecks++;
    if (if0.busy !== 1'b0 || if1.busy !== 1'b0)
      $display("[TB] FAIL clr_busy_end got %b/%b, required 0", if0.busy, if1.busy);
    else
      nPass++;
    mBusy = 1'b0;
    drive(1, 0, 4'h0, 4'd7, 32'h0, 1, 4'd3, 0);
    waitDrain();
  endtask

  task automatic test_rst_during_clear();
    drive(1, 1, 4'hF, 4'd9, 32'hCAFEF00D, 0, 4'h0, 0);
    drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nChecks++;
      if (if0.busy !== 1'b1 || if1.busy !== 1'b1)
        $display("[TB] FAIL rst_clr_busy_%0d got %b/%b, required 1", i, if0.busy, if1.busy);
      else
        nPass++;
      drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, i == 4);
    end
    nChecks++;
    if (if0.busy !== 1'b0 || if1.busy !== 1'b0)
      $display("[TB] FAIL rst_clr_busy_end got %b/%b, required 0", if0.busy, if1.busy);
    else
      nPass++;
    mBusy = 1'b0;
    drive(1, 0, 4'h0, 4'd9, 32'h0, 1, 4'd15, 0);
    waitDrain();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_clear_mid();
    test_rst_during_clear();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
